// File: rtl/dmem_bridge.sv
// RV32 load/store unit to single-beat Avalon word bus bridge; sub-word stores use read-modify-write.
// Loads take at least 3 cycles to DONE. The CPU is stalled until DONE. Misaligned requests are rejected in IDLE.
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_misaligned,
    output logic        cpu_error,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_write_value,
    output logic [4:0]  m_burstcount,
    input  logic [31:0] m_read_data,
    input  logic        m_read_data_valid,
    input  logic        m_write_wait
);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        DONE
    } state_t;

    state_t      state_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic [15:0] wdata_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] m_address_q;
    logic [31:0] m_write_value_q;
    logic        m_read_q;
    logic        m_write_q;
    logic [31:0] cpu_rdata_q;
    logic        cpu_misaligned_q;
    logic        cpu_error_q;

    logic          req_misaligned;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_val;
    logic [31:0]   merged;
    logic [CW-1:0] cnt_d;
    logic          timeout_hit;

    assign req_misaligned = ((cpu_size == 2'b01) && cpu_addr[0]) ||
                            (cpu_size[1] && (cpu_addr[1:0] != 2'b00));

    assign cpu_stall = ((state_q == IDLE) && cpu_req && !req_misaligned) ||
                       (state_q == RD_ISSUE) || (state_q == RD_WAIT) ||
                       (state_q == WR_ISSUE) || (state_q == WR_WAIT);

    always_comb begin
        lane_b = 8'(m_read_data >> {addr_lo_q, 3'b000});
        lane_h = 16'(m_read_data >> {addr_lo_q[1], 4'b0000});
        if (size_q[1]) begin
            load_val = m_read_data;
        end else if (size_q[0]) begin
            load_val = {{16{lane_h[15] & ~uns_q}}, lane_h};
        end else begin
            load_val = {{24{lane_b[7] & ~uns_q}}, lane_b};
        end
        // Only byte/half stores reach the merge, so size_q[0] alone selects half.
        merged = m_read_data;
        if (size_q[0]) begin
            merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
        end else begin
            merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    assign cnt_d       = cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_d == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q          <= IDLE;
            addr_lo_q        <= 2'b00;
            size_q           <= 2'b00;
            uns_q            <= 1'b0;
            we_q             <= 1'b0;
            wdata_q          <= 16'h0;
            cnt_q            <= '0;
            m_address_q      <= 32'h0;
            m_write_value_q  <= 32'h0;
            m_read_q         <= 1'b0;
            m_write_q        <= 1'b0;
            cpu_rdata_q      <= 32'h0;
            cpu_misaligned_q <= 1'b0;
            cpu_error_q      <= 1'b0;
        end else begin
            m_read_q         <= 1'b0;
            m_write_q        <= 1'b0;
            cpu_misaligned_q <= 1'b0;
            cpu_error_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_req && req_misaligned) begin
                        cpu_misaligned_q <= 1'b1;
                    end else if (cpu_req) begin
                        addr_lo_q   <= cpu_addr[1:0];
                        size_q      <= cpu_size;
                        uns_q       <= cpu_unsigned;
                        we_q        <= cpu_we;
                        wdata_q     <= cpu_wdata[15:0];
                        m_address_q <= {cpu_addr[31:2], 2'b00};
                        if (cpu_we && cpu_size[1]) begin
                            m_write_value_q <= cpu_wdata;
                            m_write_q       <= 1'b1;
                            state_q         <= WR_ISSUE;
                        end else begin
                            m_read_q <= 1'b1;
                            state_q  <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (m_read_data_valid) begin
                        if (we_q) begin
                            m_write_value_q <= merged;
                            m_write_q       <= 1'b1;
                            state_q         <= WR_ISSUE;
                        end else begin
                            cpu_rdata_q <= load_val;
                            state_q     <= DONE;
                        end
                    end else if (timeout_hit) begin
                        cpu_error_q <= 1'b1;
                        if (!we_q) begin
                            cpu_rdata_q <= 32'h0;
                        end
                        state_q <= DONE;
                    end else if (cnt_q != {CW{1'b1}}) begin
                        cnt_q <= cnt_d;
                    end
                end
                WR_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WR_WAIT;
                end
                WR_WAIT: begin
                    // A wait-free master lands here on its first WR_WAIT cycle, two cycles after issue.
                    if (!m_write_wait) begin
                        state_q <= DONE;
                    end else if (timeout_hit) begin
                        cpu_error_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (cnt_q != {CW{1'b1}}) begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_address      = m_address_q;
    assign m_write_value  = m_write_value_q;
    assign m_read         = m_read_q;
    assign m_write        = m_write_q;
    assign m_burstcount   = 5'd1;
    assign cpu_rdata      = cpu_rdata_q;
    assign cpu_misaligned = cpu_misaligned_q;
    assign cpu_error      = cpu_error_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed vector table, reset abort sequence, then random traffic against a memory model.
module tb_dmem_bridge;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [1:0]  cpu_size = 2'b00;
    logic        cpu_unsigned = 1'b0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_misaligned;
    logic        cpu_error;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_write_value;
    logic [4:0]  m_burstcount;
    logic [31:0] m_read_data = 32'h0;
    logic        m_read_data_valid = 1'b0;
    logic        m_write_wait = 1'b0;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .clrn(clrn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .cpu_misaligned(cpu_misaligned), .cpu_error(cpu_error),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_write_value(m_write_value), .m_burstcount(m_burstcount),
        .m_read_data(m_read_data), .m_read_data_valid(m_read_data_valid),
        .m_write_wait(m_write_wait)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        int          rd_lat;
        int          ww;
        logic [31:0] memw;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wval;
        logic        exp_err;
        logic        exp_mis;
        logic        stale;
    } vec_t;

    int checks = 0;
    int passes = 0;
    logic [31:0] mem [0:255];
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
        int unsigned v, bits, sh;
        if (sz[1]) return w;
        bits = (sz == 2'b01) ? 16 : 8;
        sh = 8 * int'(a % 4);
        v = (w >> sh) & ((32'd1 << bits) - 1);
        if (!u && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] wd);
        int unsigned bits, sh, ones;
        if (sz[1]) return wd;
        bits = (sz == 2'b01) ? 16 : 8;
        sh = 8 * int'(a % 4);
        ones = (32'd1 << bits) - 1;
        return (w & ~(ones << sh)) | ((wd & ones) << sh);
    endfunction

    function automatic logic ref_mis(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b01 && (a % 2) != 0) || (sz[1] && (a % 4) != 0);
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int cyc, nrd, nwr, cd, wl, done_at, exp_done, t;
        bit done, needs_rd, rd_to;
        logic [31:0] raddr, waddr, wval;
        cyc = 0; nrd = 0; nwr = 0; cd = 0; wl = 0; done = 0; done_at = -1;
        raddr = 32'h0; waddr = 32'h0; wval = 32'h0;
        mem[v.addr[9:2]] = v.memw;
        cpu_we = v.we; cpu_addr = v.addr; cpu_size = v.size;
        cpu_unsigned = v.uns; cpu_wdata = v.wdata; cpu_req = 1'b1;
        #1;
        if (v.exp_mis) begin
            chk(tag, "mis_stall", 32'(cpu_stall), 32'd0);
            @(negedge clk);
            chk(tag, "mis_pulse", 32'(cpu_misaligned), 32'd1);
            chk(tag, "mis_bus", 32'({m_read, m_write}), 32'd0);
            cpu_req = 1'b0;
            @(negedge clk);
            chk(tag, "mis_single", 32'({cpu_misaligned, m_read, m_write}), 32'd0);
            chk(tag, "mis_rdata", cpu_rdata, last_rdata);
            return;
        end
        chk(tag, "req_stall", 32'(cpu_stall), 32'd1);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            m_read_data_valid = 1'b0;
            if (m_read) begin
                nrd++; raddr = m_address; cd = v.rd_lat;
                if (v.stale) begin
                    m_read_data = 32'hBAD0BAD0; m_read_data_valid = 1'b1;
                end
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    m_read_data = mem[raddr[9:2]]; m_read_data_valid = 1'b1;
                end
            end
            if (m_write) begin
                nwr++; waddr = m_address; wval = m_write_value; wl = v.ww;
                m_write_wait = (v.ww > 0);
            end else if (wl > 0) begin
                wl--; m_write_wait = (wl > 0);
            end
            if (!cpu_stall) begin
                done = 1; done_at = cyc;
            end
        end
        // Expected completion cycle from the protocol timing rules.
        needs_rd = !v.we || !v.size[1];
        rd_to = needs_rd && (v.rd_lat > TO);
        t = 1; exp_done = -1;
        if (needs_rd) begin
            if (rd_to) exp_done = t + TO + 1;
            else t = t + v.rd_lat + 1;
        end
        if (exp_done < 0) begin
            if (!v.we) exp_done = t;
            else exp_done = t + ((v.ww > TO) ? TO : ((v.ww < 1) ? 1 : v.ww)) + 1;
        end
        chk(tag, "completed", 32'(done), 32'd1);
        chk(tag, "done_cycle", 32'(done_at), 32'(exp_done));
        chk(tag, "n_reads", 32'(nrd), 32'(needs_rd));
        chk(tag, "n_writes", 32'(nwr), 32'(v.we && !rd_to));
        if (needs_rd) chk(tag, "rd_addr", raddr, {v.addr[31:2], 2'b00});
        if (v.we && !rd_to) begin
            chk(tag, "wr_addr", waddr, {v.addr[31:2], 2'b00});
            chk(tag, "wr_value", wval, v.exp_wval);
        end
        chk(tag, "error", 32'(cpu_error), 32'(v.exp_err));
        if (!v.we) last_rdata = v.exp_rdata;
        chk(tag, "rdata", cpu_rdata, last_rdata);
        if (v.we && !v.exp_err) mem[v.addr[9:2]] = v.exp_wval;
        cpu_req = 1'b0; m_read_data_valid = 1'b0; m_write_wait = 1'b0;
        @(negedge clk);
        chk(tag, "idle_after", 32'({cpu_stall, cpu_error, m_read, m_write}), 32'd0);
    endtask

    vec_t tbl [13];

    initial begin
        vec_t v;
        //         we    addr        sz     uns   wdata         lat ww memw          exp_rdata     exp_wval      err   mis   stale
        tbl[0]  = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,        3,  0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h103, 2'd0, 1'b0, 32'h0,        1,  0, 32'h80FF1234, 32'hFFFFFF80, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h103, 2'd0, 1'b1, 32'h0,        2,  0, 32'h80FF1234, 32'h00000080, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'h102, 2'd1, 1'b0, 32'h0,        1,  0, 32'h80FF1234, 32'hFFFF80FF, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h201, 2'd0, 1'b0, 32'h000000AB, 2,  0, 32'h11223344, 32'h0,        32'h1122AB44, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h204, 2'd2, 1'b0, 32'hCAFEF00D, 1,  4, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h100, 2'd1, 1'b1, 32'h0,        16, 0, 32'hDEADBEEF, 32'h0000BEEF, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 32'h202, 2'd1, 1'b0, 32'h12345555, 1,  1, 32'h11223344, 32'h0,        32'h55553344, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'h108, 2'd3, 1'b0, 32'h0,        1,  0, 32'h01020304, 32'h01020304, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'h101, 2'd1, 1'b0, 32'h0,        1,  0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 32'h203, 2'd2, 1'b0, 32'h0,        1,  0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 32'h110, 2'd2, 1'b0, 32'h0,        100,0, 32'h77777777, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 32'h213, 2'd0, 1'b0, 32'h000000FF, 1, 20, 32'h0,        32'h0,        32'hFF000000, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        @(negedge clk);
        chk("reset", "regs", {m_address | m_write_value | cpu_rdata},  32'h0);
        chk("reset", "flags", 32'({m_read, m_write, cpu_misaligned, cpu_error, cpu_stall}), 32'd0);
        chk("reset", "burst", 32'(m_burstcount), 32'd1);
        clrn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset while a load is waiting for its response.
        cpu_we = 1'b0; cpu_addr = 32'h300; cpu_size = 2'd2; cpu_req = 1'b1;
        @(negedge clk);
        chk("abort", "rd_issued", 32'(m_read), 32'd1);
        @(negedge clk);
        clrn = 1'b0; cpu_req = 1'b0;
        #1;
        chk("abort", "regs", {m_address | m_write_value | cpu_rdata}, 32'h0);
        chk("abort", "flags", 32'({m_read, m_write, cpu_misaligned, cpu_error, cpu_stall}), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        last_rdata = 32'h0;
        m_read_data = 32'hBAD0BAD0; m_read_data_valid = 1'b1;
        @(negedge clk);
        m_read_data_valid = 1'b0;
        chk("abort", "late_beat", cpu_rdata, 32'h0);
        v = '{1'b0, 32'h104, 2'd2, 1'b0, 32'h0, 2, 0, 32'h13579BDF, 32'h13579BDF, 32'h0, 1'b0, 1'b0, 1'b1};
        run_txn(v, "post_reset");

        for (int i = 0; i < 40; i++) begin
            v.we = 1'($urandom);
            v.addr = $urandom;
            v.size = 2'($urandom);
            v.uns = 1'($urandom);
            v.wdata = $urandom;
            v.rd_lat = int'($urandom_range(1, 6));
            v.ww = int'($urandom_range(0, 5));
            v.memw = mem[v.addr[9:2]];
            v.exp_rdata = ref_load(v.memw, v.addr, v.size, v.uns);
            v.exp_wval = ref_store(v.memw, v.addr, v.size, v.wdata);
            v.exp_err = 1'b0;
            v.exp_mis = ref_mis(v.addr, v.size);
            v.stale = 1'($urandom);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits between the CPU load/store unit and the Avalon master's data memory bus.
- Converts RV32 byte, half and word loads/stores into single-beat word transactions. Burstcount is fixed at 1.
- The master has no byteenable, so sub-word stores are done as read-modify-write.
- Handles lane extraction, sign/zero extension, misalignment detection and a bus timeout. The CPU is stalled until completion.

Parameters:
- TIMEOUT, 1024: cycles to wait for a bus response before aborting with an error. 0 disables the timeout.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- cpu_req  in  1  load/store request, held stable while cpu_stall=1
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  32  byte address
- cpu_size  in  2  00=byte, 01=half, 10=word; 11 is treated as word
- cpu_unsigned  in  1  zero-extend load (LBU/LHU)
- cpu_wdata  in  32  store data, right-aligned
- cpu_stall  out  1  CPU must hold its request
- cpu_rdata  out  32  extended load result
- cpu_misaligned  out  1  one-cycle pulse on a misaligned access
- cpu_error  out  1  one-cycle pulse on timeout
- m_address  out  32  word-aligned address to the master
- m_read  out  1  read request pulse
- m_write  out  1  write request pulse
- m_write_value  out  32  merged write word
- m_burstcount  out  5  constant 1
- m_read_data  in  32  master read value
- m_read_data_valid  in  1  read beat valid
- m_write_wait  in  1  master busy with a write

Behaviour:
- Reset (async, clrn=0):
  - State returns to IDLE.
  - All registered outputs go to 0: m_read, m_write, m_address, m_write_value, cpu_rdata, cpu_misaligned, cpu_error.
  - m_burstcount is constant 1.
  - Reset mid-transaction discards the transaction; no completion is signalled.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - In IDLE with cpu_req=1 and misaligned: no bus access; cpu_misaligned pulses the next cycle; cpu_stall stays 0.
- Stall: cpu_stall is combinational and equals (IDLE & cpu_req & !misaligned) | state in {RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT}. cpu_stall=0 in DONE.
- IDLE, accepted request:
  - Latch addr, size, unsigned, wdata, we.
  - m_address = {addr[31:2], 2'b00}.
  - Loads and sub-word stores go to RD_ISSUE; word stores go to WR_ISSUE with m_write_value = wdata.
- RD_ISSUE:
  - m_read=1 for exactly one cycle, then RD_WAIT.
- RD_WAIT, on m_read_data_valid:
  - Load: lane = addr[1:0]. Byte selects data[8*lane+:8]; half selects data[16*addr[1]+:16]. Sign- or zero-extend, register into cpu_rdata, go to DONE.
  - Sub-word store: m_write_value = m_read_data with the addressed byte or half replaced by wdata[7:0] or wdata[15:0]; go to WR_ISSUE.
- WR_ISSUE:
  - m_write=1 for one cycle, then WR_WAIT.
  - m_write_value and m_address are held stable until DONE.
- WR_WAIT:
  - Completion is the first cycle with m_write_wait=0 after m_write_wait has been seen at 1; then go to DONE.
  - If m_write_wait was never seen high, completion is 2 cycles after WR_ISSUE.
- DONE:
  - Lasts one cycle with cpu_stall=0; returns to IDLE.
  - The CPU advances this cycle; a new request is accepted in IDLE on the following cycle. Minimum request-to-request spacing is therefore 1 cycle of DONE plus 1 cycle of IDLE.
- cpu_rdata holds its last load value until the next load completes. Stores never change it.
- Timeout:
  - A counter runs in RD_WAIT and WR_WAIT and clears on each state entry.
  - On reaching TIMEOUT: go to DONE, pulse cpu_error, set cpu_rdata=0 for loads, drop a pending write.
  - Counter width is clog2(TIMEOUT+1); it saturates and does not wrap.
- A read response arriving in any state other than RD_WAIT is ignored.
- Load latency: request to DONE is at least 3 cycles (IDLE, RD_ISSUE, RD_WAIT...).

Test Plan:
- LW addr 0x100, bus returns 0xDEADBEEF after 3 cycles -> m_read single pulse, m_address 0x100, cpu_rdata 0xDEADBEEF in DONE, cpu_stall low exactly 1 cycle at DONE.
- LB addr 0x103, word 0x80FF1234 -> cpu_rdata 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, wdata 0xAB, memory word 0x11223344 -> one read, then one write of 0x1122AB44 to 0x200.
- SW addr 0x204, 0xCAFEF00D, m_write_wait high 4 cycles -> no read, one m_write pulse, stall released the cycle after wait falls.
- LH addr 0x101 -> no m_read/m_write, cpu_misaligned pulses once, cpu_stall never high. LW with no response and TIMEOUT=16 -> cpu_error at cycle 16, cpu_rdata 0.
- clrn pulled low during RD_WAIT -> all outputs 0 immediately. After release, a new LW completes normally, and a late m_read_data_valid from the aborted read is ignored.
